// File: rtl/syscall_controller_pkg.sv
// Shared definitions for the SYSCALL controller: service codes and FSM states.
package syscall_controller_pkg;

    localparam logic [31:0] SYSCALL_PRINT = 32'd1;
    localparam logic [31:0] SYSCALL_EXIT  = 32'd10;
    localparam logic [31:0] SYSCALL_PAUSE = 32'd50;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/syscall_fifo.sv
// Print queue: power-of-two circular buffer with an extra wrap bit on each
// pointer so full and empty can be told apart.
module syscall_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue regardless of stored data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/syscall_controller.sv
// SYSCALL sequencer: decodes $v0, queues print-int arguments and paces them
// onto the board display; handles exit/pause and stalls the CPU when the
// print queue is full.
module syscall_controller
    import syscall_controller_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              syscall,
    input  logic [DATA_W-1:0] regSValue,
    input  logic [DATA_W-1:0] regTValue,
    input  logic              resume,
    output logic              stall,
    output logic              enable,
    output logic [DATA_W-1:0] displayValue,
    output logic              halted
);

    localparam int DW = $clog2(HOLD_CYCLES + 1);

    state_t            state;
    logic [DW-1:0]     dwell;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              is_print;
    logic              is_exit;
    logic              is_pause;
    logic              accept;
    logic              push;
    logic              pop;
    logic              dwell_zero;

    assign is_print   = (regSValue == DATA_W'(SYSCALL_PRINT));
    assign is_exit    = (regSValue == DATA_W'(SYSCALL_EXIT));
    assign is_pause   = (regSValue == DATA_W'(SYSCALL_PAUSE));
    assign enable     = (state == ST_RUN);
    assign halted     = (state == ST_HALTED);
    // Full stalls even when a pop frees a slot on the same edge (no bypass).
    assign stall      = (state == ST_RUN) && syscall && is_print && fifo_full;
    assign accept     = syscall && enable && !stall;
    assign push       = accept && is_print;
    assign dwell_zero = (dwell == '0);
    assign pop        = dwell_zero && !fifo_empty;

    syscall_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .wdata(regTValue),
        .pop  (pop),
        .head (fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Run-state FSM: pause/resume, exit drains the display before halting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept && is_exit)       state <= ST_DRAIN;
                    else if (accept && is_pause) state <= ST_PAUSED;
                end
                ST_PAUSED: if (resume) state <= ST_RUN;
                ST_DRAIN:  if (fifo_empty && dwell_zero) state <= ST_HALTED;
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

    // Display pacing: each popped value is held for HOLD_CYCLES edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            displayValue <= '0;
            dwell        <= '0;
        end else if (pop) begin
            displayValue <= fifo_head;
            dwell        <= DW'(HOLD_CYCLES);
        end else if (!dwell_zero) begin
            dwell <= dwell - DW'(1);
        end
    end

endmodule

// File: tb/tb_syscall_controller.sv
// Self-checking bench for syscall_controller: hand-computed vector table,
// directed corner sequences and randomized traffic against a queue model.
module tb_syscall_controller;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int HOLD   = 4;

    localparam int M_RUN    = 0;
    localparam int M_PAUSED = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_HALTED = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              syscall;
    logic [DATA_W-1:0] regSValue;
    logic [DATA_W-1:0] regTValue;
    logic              resume;
    logic              stall;
    logic              enable;
    logic [DATA_W-1:0] displayValue;
    logic              halted;

    int errors = 0;
    int checks = 0;

    // Behavioural model
    logic [31:0] mq[$];
    int          m_mode;
    int          m_dwell;
    logic [31:0] m_disp;

    typedef struct {
        logic        sc;
        logic [31:0] code;
        logic [31:0] arg;
        logic        res;
        logic        exp_stall;
        logic [31:0] exp_disp;
        logic        exp_enable;
        logic        exp_halted;
    } vec_t;

    syscall_controller #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .syscall     (syscall),
        .regSValue   (regSValue),
        .regTValue   (regTValue),
        .resume      (resume),
        .stall       (stall),
        .enable      (enable),
        .displayValue(displayValue),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_mode  = M_RUN;
        m_dwell = 0;
        m_disp  = '0;
    endfunction

    function automatic logic model_stall(input logic sc, input logic [31:0] code);
        return (m_mode == M_RUN) && sc && (code == 32'd1) && (mq.size() == DEPTH);
    endfunction

    // One clock edge of the spec's behaviour, using the values seen before the edge.
    function automatic void model_step(input logic sc, input logic [31:0] code,
                                       input logic [31:0] arg, input logic res);
        bit was_empty;
        int dwell0;
        bit acc;
        was_empty = (mq.size() == 0);
        dwell0    = m_dwell;
        acc       = sc && (m_mode == M_RUN) && !model_stall(sc, code);
        if (dwell0 == 0 && !was_empty) begin
            m_disp  = mq.pop_front();
            m_dwell = HOLD;
        end else if (dwell0 > 0) begin
            m_dwell = dwell0 - 1;
        end
        if (acc && code == 32'd1) mq.push_back(arg);
        case (m_mode)
            M_RUN: begin
                if (acc && code == 32'd10)      m_mode = M_DRAIN;
                else if (acc && code == 32'd50) m_mode = M_PAUSED;
            end
            M_PAUSED: if (res) m_mode = M_RUN;
            M_DRAIN:  if (was_empty && dwell0 == 0) m_mode = M_HALTED;
            default:  m_mode = m_mode;
        endcase
    endfunction

    task automatic drive(input logic sc, input logic [31:0] code, input logic [31:0] arg,
                         input logic res);
        @(negedge clock);
        syscall   = sc;
        regSValue = code;
        regTValue = arg;
        resume    = res;
        #1;
    endtask

    task automatic clock_edge();
        @(posedge clock);
        model_step(syscall, regSValue, regTValue, resume);
        #1;
    endtask

    // Full cycle compared against the model.
    task automatic mcycle(input logic sc, input logic [31:0] code, input logic [31:0] arg,
                          input logic res);
        drive(sc, code, arg, res);
        check("stall", {31'd0, stall}, {31'd0, model_stall(sc, code)});
        check("enable_pre", {31'd0, enable}, {31'd0, m_mode == M_RUN});
        clock_edge();
        check("display", displayValue, m_disp);
        check("enable", {31'd0, enable}, {31'd0, m_mode == M_RUN});
        check("halted", {31'd0, halted}, {31'd0, m_mode == M_HALTED});
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clock);
        #2;
        syscall = 1'b0;
        resume  = 1'b0;
        reset   = 1'b1;
        #1;
        check("rst_enable", {31'd0, enable}, 32'd1);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_display", displayValue, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    vec_t vecs[13];

    initial begin
        int stalls_seen;
        int halted_cycles;
        int budget;
        int r;
        logic [31:0] code;

        reset     = 1'b1;
        syscall   = 1'b0;
        regSValue = '0;
        regTValue = '0;
        resume    = 1'b0;
        model_reset();
        #12;
        check("init_enable", {31'd0, enable}, 32'd1);
        check("init_display", displayValue, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // PRINT 100, PRINT 200, EXIT: show/hold pacing and drain to halt.
        vecs[0]  = '{1'b1, 32'd1,  32'd100, 1'b0, 1'b0, 32'd0,   1'b1, 1'b0};
        vecs[1]  = '{1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 32'd100, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 32'd100, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 32'd100, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 32'd100, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'd1,  32'd200, 1'b0, 1'b0, 32'd100, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'd10, 32'd0,   1'b0, 1'b0, 32'd200, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'd1,  32'd9,   1'b0, 1'b0, 32'd200, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'd0,  32'd0,   1'b1, 1'b0, 32'd200, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 32'd200, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 32'd200, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'd0,  32'd0,   1'b0, 1'b0, 32'd200, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 32'd1,  32'd5,   1'b0, 1'b0, 32'd200, 1'b0, 1'b1};
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].sc, vecs[i].code, vecs[i].arg, vecs[i].res);
            check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
            clock_edge();
            check($sformatf("vec%0d_disp", i), displayValue, vecs[i].exp_disp);
            check($sformatf("vec%0d_enable", i), {31'd0, enable}, {31'd0, vecs[i].exp_enable});
            check($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halted});
        end

        // Back-to-back PRINTs until the queue fills; CPU holds while stalled.
        do_reset();
        stalls_seen = 0;
        for (int v = 1; v <= 8; v++) begin
            budget = 0;
            forever begin
                drive(1'b1, 32'd1, 32'(v), 1'b0);
                if (stall) stalls_seen++;
                check("fill_stall", {31'd0, stall}, {31'd0, model_stall(1'b1, 32'd1)});
                if (!stall) break;
                clock_edge();
                check("fill_disp", displayValue, m_disp);
                budget++;
                if (budget > 20) begin
                    check("fill_stall_timeout", 32'd1, 32'd0);
                    break;
                end
            end
            clock_edge();
            check("fill_disp", displayValue, m_disp);
        end
        check("fill_stall_seen", {31'd0, stalls_seen > 0}, 32'd1);
        repeat (40) mcycle(1'b0, 32'd0, 32'd0, 1'b0);
        check("fill_last_shown", displayValue, 32'd8);

        // PAUSE with values queued; resume in PAUSED and in RUN.
        do_reset();
        mcycle(1'b1, 32'd1, 32'd11, 1'b0);
        mcycle(1'b1, 32'd1, 32'd22, 1'b0);
        mcycle(1'b1, 32'd50, 32'd0, 1'b0);
        check("pause_enable", {31'd0, enable}, 32'd0);
        mcycle(1'b1, 32'd1, 32'd33, 1'b0);
        mcycle(1'b1, 32'd7, 32'd44, 1'b0);
        repeat (10) mcycle(1'b0, 32'd0, 32'd0, 1'b0);
        check("pause_drained", displayValue, 32'd22);
        mcycle(1'b0, 32'd0, 32'd0, 1'b1);
        check("resume_enable", {31'd0, enable}, 32'd1);
        mcycle(1'b0, 32'd0, 32'd0, 1'b1);
        mcycle(1'b1, 32'd7, 32'd55, 1'b0);
        repeat (6) mcycle(1'b0, 32'd0, 32'd0, 1'b0);
        check("unknown_no_push", displayValue, 32'd22);

        // Reset while draining discards queued values.
        mcycle(1'b1, 32'd1, 32'd66, 1'b0);
        mcycle(1'b1, 32'd1, 32'd77, 1'b0);
        mcycle(1'b1, 32'd10, 32'd0, 1'b0);
        check("drain_enable", {31'd0, enable}, 32'd0);
        do_reset();
        repeat (8) mcycle(1'b0, 32'd0, 32'd0, 1'b0);
        check("drain_reset_disp", displayValue, 32'd0);

        // Randomized traffic against the model.
        halted_cycles = 0;
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 15));
            if (r <= 6)       code = 32'd1;
            else if (r == 7)  code = ($urandom_range(0, 3) == 0) ? 32'd10 : 32'd7;
            else if (r <= 9)  code = 32'd50;
            else if (r <= 11) code = 32'd7;
            else              code = $urandom;
            mcycle($urandom_range(0, 9) < 7, code, $urandom, $urandom_range(0, 5) == 0);
            if (m_mode == M_HALTED) halted_cycles++;
            if (halted_cycles > 3 || $urandom_range(0, 199) == 0) begin
                halted_cycles = 0;
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
